// File: rtl/alu_operand_pkg.sv
// Shared types and constants for the ALU operand stage: select encodings,
// skid-buffer state encoding and the illegal-select counter ceiling.
package alu_operand_pkg;

  typedef enum logic [1:0] {
    SRC1_PC   = 2'b00,
    SRC1_RF   = 2'b01,
    SRC1_ZERO = 2'b10,
    SRC1_FWD  = 2'b11
  } src1_sel_e;

  typedef enum logic [1:0] {
    SRC2_INC = 2'b00,
    SRC2_IMM = 2'b01,
    SRC2_RF  = 2'b10,
    SRC2_FWD = 2'b11
  } src2_sel_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

  localparam logic [7:0] SEL_ERR_MAX = 8'd255;

endpackage

// File: rtl/alu_operand_skid.sv
// Two-entry skid buffer: the main slot drives the output, and the skid slot
// catches one extra beat so in_ready depends only on registered state.
module alu_operand_skid
  import alu_operand_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   state_dbg
);

  // Handshake: a beat transfers on a rising clk edge where valid and ready
  // are both 1; ready never depends combinationally on valid.
  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         load_main, load_skid, move_skid;
  logic         in_fire, out_fire;

  assign in_fire   = in_valid && (state_q != SKID_FULL);
  assign out_fire  = out_ready && (state_q != SKID_EMPTY);
  assign out_data  = main_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= SKID_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: if (in_fire) begin
          state_d   = SKID_ONE;
          load_main = 1'b1;
        end
        SKID_ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_d   = SKID_FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: if (out_fire) begin
          state_d   = SKID_ONE;
          move_skid = 1'b1;
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)      main_q <= in_data;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand select stage: decodes src1/src2, buffers them with the op tag
// in a skid buffer, and counts illegal selects. Optional: ALU_OPERAND_FWD_EN.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int INC_VAL = 4,
  parameter int OP_W    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        sel1,
  input  logic [1:0]        sel2,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [OP_W-1:0]   op_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [OP_W-1:0]   op_out,
  output logic              sel_err,
  output logic [7:0]        sel_err_cnt
);

  localparam int PW = 2 * DATA_W + OP_W;
  localparam logic [DATA_W-1:0] INC_OP = DATA_W'(INC_VAL);

  src1_sel_e         s1;
  src2_sel_e         s2;
  logic [DATA_W-1:0] src1, src2;
  logic              err1, err2;
  logic              in_fire, sel_hit;
  logic [PW-1:0]     out_data;
  logic [1:0]        skid_state;

  assign s1 = src1_sel_e'(sel1);
  assign s2 = src2_sel_e'(sel2);

  always_comb begin
    src1 = '0;
    err1 = 1'b0;
    case (s1)
      SRC1_PC:   src1 = pc;
      SRC1_RF:   src1 = rf_rdata1;
      SRC1_ZERO: src1 = '0;
      SRC1_FWD: begin
`ifdef ALU_OPERAND_FWD_EN
        src1 = alu_result;
`else
        err1 = 1'b1;
`endif
      end
      default:   src1 = '0;
    endcase
  end

  always_comb begin
    src2 = INC_OP;
    err2 = 1'b0;
    case (s2)
      SRC2_INC: src2 = INC_OP;
      SRC2_IMM: src2 = imm;
      SRC2_RF:  src2 = rf_rdata2;
      SRC2_FWD: begin
`ifdef ALU_OPERAND_FWD_EN
        src2 = alu_result;
`else
        err2 = 1'b1;
`endif
      end
      default:  src2 = INC_OP;
    endcase
  end

`ifndef ALU_OPERAND_FWD_EN
  logic unused_alu_result;
  assign unused_alu_result = ^alu_result;
`endif

  assign in_ready  = (skid_state_e'(skid_state) != SKID_FULL);
  assign out_valid = (skid_state_e'(skid_state) != SKID_EMPTY);
  assign in_fire   = in_valid && in_ready;
  // A flushed beat is discarded, so its select is not counted as accepted.
  assign sel_hit   = in_fire && !flush && (err1 || err2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_err     <= 1'b0;
      sel_err_cnt <= '0;
    end else if (sel_hit) begin
      sel_err <= 1'b1;
      if (sel_err_cnt != SEL_ERR_MAX) sel_err_cnt <= sel_err_cnt + 8'd1;
    end
  end

  alu_operand_skid #(.W(PW)) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   ({op_in, src1, src2}),
    .out_ready (out_ready),
    .out_data  (out_data),
    .state_dbg (skid_state)
  );

  assign op_out   = out_data[PW-1 -: OP_W];
  assign alu_src1 = out_data[2*DATA_W-1 -: DATA_W];
  assign alu_src2 = out_data[DATA_W-1:0];

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, default 32, SHALL set the operand width.
REQ-003 Parameter INC_VAL, default 4, SHALL set the constant-increment operand.
REQ-004 Parameter OP_W, default 4, SHALL set the width of the pass-through ALU op tag.
REQ-005 The block SHALL have the following ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  request valid
- in_ready  out  1  stage can accept
- sel1  in  2  src1 select
- sel2  in  2  src2 select
- pc  in  DATA_W  program counter
- rf_rdata1  in  DATA_W  register file read data 1
- rf_rdata2  in  DATA_W  register file read data 2
- imm  in  DATA_W  immediate
- alu_result  in  DATA_W  fed-back ALU result
- op_in  in  OP_W  ALU op tag
- out_valid  out  1  operands valid
- out_ready  in  1  ALU accepts
- alu_src1  out  DATA_W  registered operand 1
- alu_src2  out  DATA_W  registered operand 2
- op_out  out  OP_W  registered op tag
- sel_err  out  1  sticky illegal-select flag
- sel_err_cnt  out  8  saturating illegal-select count

Function
REQ-006 Operand 1 decode SHALL be: sel1 00 gives pc, 01 gives rf_rdata1, 10 gives zero, 11 gives see REQ-016.
REQ-007 Operand 2 decode SHALL be: sel2 00 gives INC_VAL (zero-extended to DATA_W), 01 gives imm, 10 gives rf_rdata2, 11 gives see REQ-016.
REQ-008 Selection SHALL be evaluated and captured only on in_fire (in_valid and in_ready).
REQ-009 Storage SHALL be a 2-entry skid buffer with states EMPTY, ONE and FULL.
REQ-010 in_ready SHALL be 1 whenever the state is not FULL.
REQ-011 out_valid SHALL be 1 whenever the state is not EMPTY.
REQ-012 Latency from in_fire to out_valid SHALL be 1 cycle.
REQ-013 State transitions SHALL be:
- EMPTY with in_fire goes to ONE.
- ONE with in_fire and no out_fire goes to FULL, with the new entry placed in the skid slot.
- ONE with in_fire and out_fire stays ONE, with the main slot replaced.
- ONE with out_fire only goes to EMPTY.
- FULL with out_fire goes to ONE, with the skid slot moved to the main slot.
REQ-014 Output ordering SHALL be strict FIFO, and alu_src1, alu_src2 and op_out SHALL stay stable while out_valid is 1 and out_ready is 0.
REQ-015 flush SHALL force the state to EMPTY on the next edge, and SHALL discard any simultaneous in_fire and out_fire data.
REQ-016 An accepted select value of 11 without the macro SHALL:
- output zero (src1) or INC_VAL (src2);
- set sel_err;
- increment sel_err_cnt, saturating at 255.
REQ-017 When both selects on the same in_fire are illegal, sel_err_cnt SHALL increment by 1 only.
REQ-018 flush SHALL NOT clear sel_err or sel_err_cnt.

Reset
REQ-019 On rstn low, the state SHALL be EMPTY, giving in_ready=1 and out_valid=0.
REQ-020 On rstn low, alu_src1, alu_src2, op_out, sel_err and sel_err_cnt SHALL all be 0.
REQ-021 Reset asserted mid-transfer SHALL drop all buffered entries without generating an output.

Configuration
REQ-022 Macro ALU_OPERAND_FWD_EN, when defined, SHALL make select value 11 legal on both operands, selecting alu_result as sampled at in_fire, with no sel_err effect.
REQ-023 When ALU_OPERAND_FWD_EN is undefined, the alu_result port SHALL exist but be unused, and REQ-016 applies.

Structure
REQ-024 Package alu_operand_pkg SHALL hold:
- the src1 and src2 select enums;
- the skid-state enum;
- the SEL_ERR_MAX constant (255).
REQ-025 The skid buffer SHALL be a sub-module alu_operand_skid, parametrised by payload width (2*DATA_W+OP_W).
REQ-026 The select decode and error counter SHALL reside in alu_operand_stage.

Verification
REQ-027 Basic pass: sel1=00, pc=0x100, sel2=00, out_ready=1 -> next cycle alu_src1=0x100, alu_src2=0x4, out_valid=1.
REQ-028 Backpressure: out_ready=0, then 3 back-to-back requests with imm=1,2,3 -> in_ready drops after the 2nd, and outputs in order 1,2 once released.
REQ-029 Simultaneous: state ONE with in_fire and out_fire -> stays ONE, and outputs the new request next cycle.
REQ-030 Illegal select without the macro: sel2=11 accepted 300 times -> sel_err=1, sel_err_cnt=255, alu_src2=0x4.
REQ-031 Forwarding with ALU_OPERAND_FWD_EN: sel1=11, alu_result=0xDEAD -> alu_src1=0xDEAD, sel_err=0.
REQ-032 Flush in FULL, and rstn pulsed mid-stream -> next cycle out_valid=0, in_ready=1, and no stale output appears.
